// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EXE operand forwarding, load-use and load-wait stalls,
// pipeline flush/redirect steering, and stall/hazard performance counters.
module hazard_fwd_unit #(
  parameter int NSRC  = 2,
  parameter int NFWD  = 2,
  parameter int REGW  = 5,
  parameter int LD_TO = 0,
  parameter int CNTW  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*REGW-1:0] src_addr_i,
  input  logic [NSRC-1:0]      src_use_i,
  input  logic [NFWD*REGW-1:0] prod_rd_i,
  input  logic [NFWD-1:0]      prod_wr_i,
  input  logic [NFWD-1:0]      prod_late_i,
  input  logic                 ld_req_i,
  input  logic                 ld_ack_i,
  input  logic                 exe_pc_req_i,
  input  logic                 csr_pc_req_i,
  input  logic                 wfi_req_i,
  input  logic                 cnt_clr_i,
  output logic [NSRC*NFWD-1:0] fwd_sel_o,
  output logic                 front_stall_o,
  output logic                 lsu_stall_o,
  output logic                 front_flush_o,
  output logic                 lsu_flush_o,
  output logic                 if_exe_pc_o,
  output logic                 if_csr_pc_o,
  output logic                 if_wfi_o,
  output logic                 ld_timeout_o,
  output logic [CNTW-1:0]      stall_cnt_o,
  output logic [CNTW-1:0]      hazard_cnt_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [NSRC-1:0][NFWD-1:0] match;
  logic [NSRC-1:0][NFWD-1:0] sel;
  logic [NSRC-1:0]           late_use;

  logic uh_raw;
  logic uh;
  logic ld_stall;
  logic epc;
  logic to_hit;

  logic [0:0] state_q;
  logic [0:0] state_d;

  logic [CNTW-1:0] scnt_q;
  logic [CNTW-1:0] scnt_d;
  logic [CNTW-1:0] hcnt_q;
  logic [CNTW-1:0] hcnt_d;

  // match each operand against producers, keep only the youngest hit
  always_comb begin
    match     = '0;
    sel       = '0;
    late_use  = '0;
    fwd_sel_o = '0;
    for (int j = 0; j < NSRC; j++) begin
      for (int k = 0; k < NFWD; k++) begin
        match[j][k] =
          (src_addr_i[j*REGW +: REGW] != '0) &&
          (src_addr_i[j*REGW +: REGW] ==
           prod_rd_i[k*REGW +: REGW]) &&
          prod_wr_i[k];
      end
      sel[j] = match[j] & (~match[j] + NFWD'(1));
      late_use[j] = src_use_i[j] &
                    (|(sel[j] & prod_late_i));
      fwd_sel_o[j*NFWD +: NFWD] = sel[j] & ~prod_late_i;
    end
  end

  assign uh_raw   = |late_use;
  assign ld_stall = ~ld_ack_i &
                    (ld_req_i | (state_q == S_WAIT));
  assign uh       = uh_raw & ~ld_stall;
  assign epc      = exe_pc_req_i & ~(uh | ld_stall);

  assign front_stall_o = uh | ld_stall;
  assign lsu_stall_o   = ld_stall;
  assign front_flush_o = epc | csr_pc_req_i | wfi_req_i;
  assign lsu_flush_o   = uh | csr_pc_req_i | wfi_req_i;
  assign if_exe_pc_o   = epc & ~csr_pc_req_i;
  assign if_csr_pc_o   = csr_pc_req_i;
  assign if_wfi_o      = wfi_req_i;
  assign ld_timeout_o  = to_hit;

  generate
    if (LD_TO > 0) begin : g_to
      localparam int TOW = (LD_TO > 1) ? $clog2(LD_TO) : 1;

      logic [TOW-1:0] wcnt_q;
      logic [TOW-1:0] wcnt_d;

      // wait counter: zero while idle, counts WAIT cycles
      always_comb begin
        wcnt_d = '0;
        if (state_q == S_WAIT) begin
          wcnt_d = wcnt_q + TOW'(1);
        end
      end

      // wait counter register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wcnt_q <= '0;
        end else begin
          wcnt_q <= wcnt_d;
        end
      end

      assign to_hit = (state_q == S_WAIT) &&
                      (wcnt_q == TOW'(LD_TO - 1)) &&
                      !ld_ack_i;
    end else begin : g_no_to
      assign to_hit = 1'b0;
    end
  endgenerate

  // load FSM: wait for the data-bus response or give up on timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ld_req_i && !ld_ack_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ld_ack_i || to_hit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // load FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // saturating stall counter, clear wins over increment
  always_comb begin
    scnt_d = scnt_q;
    if (cnt_clr_i) begin
      scnt_d = '0;
    end else if (front_stall_o &&
                 (scnt_q != {CNTW{1'b1}})) begin
      scnt_d = scnt_q + CNTW'(1);
    end
  end

  // saturating use-hazard counter, clear wins over increment
  always_comb begin
    hcnt_d = hcnt_q;
    if (cnt_clr_i) begin
      hcnt_d = '0;
    end else if (uh &&
                 (hcnt_q != {CNTW{1'b1}})) begin
      hcnt_d = hcnt_q + CNTW'(1);
    end
  end

  // performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      hcnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
      hcnt_q <= hcnt_d;
    end
  end

  assign stall_cnt_o  = scnt_q;
  assign hazard_cnt_o = hcnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: vector table, hand sequences for load timing,
// counters and reset, then random stimulus against a reference model.
module tb_hazard_fwd_unit;

  localparam int NSRC  = 2;
  localparam int NFWD  = 3;
  localparam int REGW  = 5;
  localparam int LD_TO = 4;
  localparam int CNTW  = 3;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [NSRC*REGW-1:0] src_addr_i;
  logic [NSRC-1:0]      src_use_i;
  logic [NFWD*REGW-1:0] prod_rd_i;
  logic [NFWD-1:0]      prod_wr_i;
  logic [NFWD-1:0]      prod_late_i;
  logic ld_req_i, ld_ack_i;
  logic exe_pc_req_i, csr_pc_req_i, wfi_req_i;
  logic cnt_clr_i;
  logic [NSRC*NFWD-1:0] fwd_sel_o;
  logic front_stall_o, lsu_stall_o;
  logic front_flush_o, lsu_flush_o;
  logic if_exe_pc_o, if_csr_pc_o, if_wfi_o;
  logic ld_timeout_o;
  logic [CNTW-1:0] stall_cnt_o, hazard_cnt_o;

  always #5 clk = ~clk;

  hazard_fwd_unit #(
    .NSRC(NSRC), .NFWD(NFWD), .REGW(REGW),
    .LD_TO(LD_TO), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_addr_i(src_addr_i), .src_use_i(src_use_i),
    .prod_rd_i(prod_rd_i), .prod_wr_i(prod_wr_i),
    .prod_late_i(prod_late_i),
    .ld_req_i(ld_req_i), .ld_ack_i(ld_ack_i),
    .exe_pc_req_i(exe_pc_req_i),
    .csr_pc_req_i(csr_pc_req_i),
    .wfi_req_i(wfi_req_i), .cnt_clr_i(cnt_clr_i),
    .fwd_sel_o(fwd_sel_o),
    .front_stall_o(front_stall_o),
    .lsu_stall_o(lsu_stall_o),
    .front_flush_o(front_flush_o),
    .lsu_flush_o(lsu_flush_o),
    .if_exe_pc_o(if_exe_pc_o),
    .if_csr_pc_o(if_csr_pc_o),
    .if_wfi_o(if_wfi_o),
    .ld_timeout_o(ld_timeout_o),
    .stall_cnt_o(stall_cnt_o),
    .hazard_cnt_o(hazard_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string        name;
    logic [9:0]   src;
    logic [1:0]   uses;
    logic [14:0]  rd;
    logic [2:0]   wr;
    logic [2:0]   late;
    logic [4:0]   ctl;
    logic [5:0]   fwd;
    logic [6:0]   fl;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {12'd0, fwd_sel_o, front_stall_o, lsu_stall_o,
            front_flush_o, lsu_flush_o, if_exe_pc_o,
            if_csr_pc_o, if_wfi_o, ld_timeout_o,
            stall_cnt_o, hazard_cnt_o};
  endfunction

  function automatic logic [13:0] ctl_vec();
    return {fwd_sel_o, front_stall_o, lsu_stall_o,
            front_flush_o, lsu_flush_o, if_exe_pc_o,
            if_csr_pc_o, if_wfi_o, ld_timeout_o};
  endfunction

  function automatic vec_t mkv(
    input string n, input int s0, input int s1,
    input logic [1:0] u, input int r0, input int r1,
    input int r2, input logic [2:0] wr,
    input logic [2:0] late, input logic [4:0] ctl,
    input logic [5:0] fwd, input logic [6:0] fl);
    vec_t v;
    v.name = n;
    v.src  = {s1[4:0], s0[4:0]};
    v.uses = u;
    v.rd   = {r2[4:0], r1[4:0], r0[4:0]};
    v.wr   = wr;
    v.late = late;
    v.ctl  = ctl;
    v.fwd  = fwd;
    v.fl   = fl;
    return v;
  endfunction

  task automatic zero_in();
    src_addr_i = '0; src_use_i = '0;
    prod_rd_i = '0; prod_wr_i = '0; prod_late_i = '0;
    ld_req_i = 0; ld_ack_i = 0;
    exe_pc_req_i = 0; csr_pc_req_i = 0; wfi_req_i = 0;
    cnt_clr_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_uh();
    src_addr_i = 10'd7; src_use_i = 2'b01;
    prod_rd_i = 15'd7; prod_wr_i = 3'b001;
    prod_late_i = 3'b001;
  endtask

  task automatic clear_cnt();
    zero_in();
    cnt_clr_i = 1;
    step();
    cnt_clr_i = 0;
  endtask

  // reference model state
  bit m_wait;
  int m_issue, cyc, m_s, m_h;
  bit e_fs, e_uh, e_to;

  function automatic logic [31:0] model_eval();
    bit lds, uhr, uh, fs, epc, to;
    logic [5:0] ef;
    int a;
    ef  = '0;
    uhr = 0;
    lds = !ld_ack_i && (ld_req_i || m_wait);
    to  = m_wait && !ld_ack_i &&
          (cyc - m_issue == LD_TO);
    for (int j = 0; j < NSRC; j++) begin
      a = int'(src_addr_i[j*REGW +: REGW]);
      for (int k = 0; k < NFWD; k++) begin
        if (a != 0 && prod_wr_i[k] &&
            a == int'(prod_rd_i[k*REGW +: REGW])) begin
          if (prod_late_i[k]) uhr = uhr | src_use_i[j];
          else ef[j*NFWD + k] = 1'b1;
          break;
        end
      end
    end
    uh  = uhr && !lds;
    fs  = uh || lds;
    epc = exe_pc_req_i && !fs;
    e_fs = fs; e_uh = uh; e_to = to;
    return {12'd0, ef, fs, lds,
            epc | csr_pc_req_i | wfi_req_i,
            uh | csr_pc_req_i | wfi_req_i,
            epc & !csr_pc_req_i, csr_pc_req_i,
            wfi_req_i, to,
            m_s[CNTW-1:0], m_h[CNTW-1:0]};
  endfunction

  task automatic model_commit();
    if (cnt_clr_i) begin
      m_s = 0; m_h = 0;
    end else begin
      if (e_fs && m_s < CMAX) m_s++;
      if (e_uh && m_h < CMAX) m_h++;
    end
    if (m_wait) begin
      if (ld_ack_i || e_to) m_wait = 0;
    end else if (ld_req_i && !ld_ack_i) begin
      m_wait = 1;
      m_issue = cyc;
    end
    cyc++;
  endtask

  task automatic do_reset();
    zero_in();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    m_wait = 0; m_s = 0; m_h = 0; cyc = 0; m_issue = 0;
  endtask

  initial begin
    logic [31:0] exp;
    zero_in();
    rst_n = 0;
    #12;
    @(negedge clk);
    chk("reset_all_zero", dut_vec(), 32'd0);
    step();
    rst_n = 1;

    // fwd bits {op1[2:0],op0[2:0]}; fl {fs,ls,ff,lf,iexe,icsr,iwfi}
    // ctl {ld_req,ld_ack,exe,csr,wfi}
    tbl.push_back(mkv("fwd_basic", 3, 5, 2'b11, 5, 5, 0,
      3'b011, 3'b000, 5'b00000, 6'b001000, 7'b0000000));
    tbl.push_back(mkv("use_hz", 7, 0, 2'b01, 7, 0, 0,
      3'b001, 3'b001, 5'b00000, 6'b000000, 7'b1001000));
    tbl.push_back(mkv("use_off", 7, 0, 2'b00, 7, 0, 0,
      3'b001, 3'b001, 5'b00000, 6'b000000, 7'b0000000));
    tbl.push_back(mkv("x0_nomatch", 0, 0, 2'b11, 0, 0, 0,
      3'b111, 3'b000, 5'b00000, 6'b000000, 7'b0000000));
    tbl.push_back(mkv("mask_old", 9, 0, 2'b01, 9, 9, 9,
      3'b111, 3'b001, 5'b00000, 6'b000000, 7'b1001000));
    tbl.push_back(mkv("skip_nowr", 9, 0, 2'b01, 9, 9, 0,
      3'b010, 3'b000, 5'b00000, 6'b000010, 7'b0000000));
    tbl.push_back(mkv("oldest", 0, 4, 2'b10, 1, 2, 4,
      3'b111, 3'b000, 5'b00000, 6'b100000, 7'b0000000));
    tbl.push_back(mkv("exe_csr", 0, 0, 2'b00, 0, 0, 0,
      3'b000, 3'b000, 5'b00110, 6'b000000, 7'b0011010));
    tbl.push_back(mkv("exe_only", 0, 0, 2'b00, 0, 0, 0,
      3'b000, 3'b000, 5'b00100, 6'b000000, 7'b0010100));
    tbl.push_back(mkv("wfi", 0, 0, 2'b00, 0, 0, 0,
      3'b000, 3'b000, 5'b00001, 6'b000000, 7'b0011001));
    tbl.push_back(mkv("exe_blk_uh", 7, 0, 2'b01, 7, 0, 0,
      3'b001, 3'b001, 5'b00100, 6'b000000, 7'b1001000));
    tbl.push_back(mkv("ld_req_ack", 0, 0, 2'b00, 0, 0, 0,
      3'b000, 3'b000, 5'b11000, 6'b000000, 7'b0000000));
    tbl.push_back(mkv("late_unused", 6, 8, 2'b01, 8, 0, 0,
      3'b001, 3'b001, 5'b00000, 6'b000000, 7'b0000000));
    tbl.push_back(mkv("both_ops", 2, 2, 2'b11, 3, 2, 2,
      3'b111, 3'b000, 5'b00000, 6'b010010, 7'b0000000));
    tbl.push_back(mkv("late_old_fwd", 5, 0, 2'b01, 1, 5, 5,
      3'b111, 3'b100, 5'b00000, 6'b000010, 7'b0000000));

    foreach (tbl[i]) begin
      zero_in();
      src_addr_i = tbl[i].src;
      src_use_i = tbl[i].uses;
      prod_rd_i = tbl[i].rd;
      prod_wr_i = tbl[i].wr;
      prod_late_i = tbl[i].late;
      {ld_req_i, ld_ack_i, exe_pc_req_i,
       csr_pc_req_i, wfi_req_i} = tbl[i].ctl;
      @(negedge clk);
      chk(tbl[i].name, {18'd0, ctl_vec()},
          {18'd0, tbl[i].fwd, tbl[i].fl, 1'b0});
      step();
    end

    // load with ack after three wait cycles: four stall cycles
    clear_cnt();
    for (int c = 0; c < 6; c++) begin
      ld_req_i = (c == 0);
      ld_ack_i = (c == 4);
      exe_pc_req_i = (c == 2);
      @(negedge clk);
      chk($sformatf("ld_stall_c%0d", c),
          {30'd0, front_stall_o, lsu_stall_o},
          (c < 4) ? 32'd3 : 32'd0);
      if (c == 2) chk("exe_blocked", 32'(if_exe_pc_o), 32'd0);
      if (c == 4) chk("ack_beats_to", 32'(ld_timeout_o), 32'd0);
      step();
    end
    chk("ld_stall_cnt", 32'(stall_cnt_o), 32'd4);

    // no ack: timeout pulse in the 4th wait cycle, idle after
    zero_in();
    for (int c = 0; c < 7; c++) begin
      ld_req_i = (c == 0);
      @(negedge clk);
      chk($sformatf("to_pulse_c%0d", c),
          {30'd0, lsu_stall_o, ld_timeout_o},
          (c < 4) ? 32'd2 : (c == 4) ? 32'd3 : 32'd0);
      step();
    end

    // csr redirect during a pending load does not abort it
    zero_in();
    for (int c = 0; c < 5; c++) begin
      ld_req_i = (c == 0);
      csr_pc_req_i = (c == 1);
      ld_ack_i = (c == 3);
      @(negedge clk);
      chk($sformatf("csr_keep_c%0d", c),
          32'(lsu_stall_o), (c < 3) ? 32'd1 : 32'd0);
      step();
    end

    // counters saturate, clear beats a live stall
    clear_cnt();
    set_uh();
    repeat (10) step();
    chk("sat_stall", 32'(stall_cnt_o), 32'd7);
    chk("sat_hazard", 32'(hazard_cnt_o), 32'd7);
    cnt_clr_i = 1;
    step();
    cnt_clr_i = 0;
    chk("clr_stall", 32'(stall_cnt_o), 32'd0);
    chk("clr_hazard", 32'(hazard_cnt_o), 32'd0);
    step();
    chk("hazard_plus1", 32'(hazard_cnt_o), 32'd1);
    src_use_i = 2'b00;
    step();
    chk("hazard_nouse", 32'(hazard_cnt_o), 32'd1);

    // reset in the middle of a load, then a stale ack
    zero_in();
    ld_req_i = 1;
    step();
    ld_req_i = 0;
    #2;
    chk("pre_rst_wait", 32'(lsu_stall_o), 32'd1);
    rst_n = 0;
    #1;
    chk("rst_async", dut_vec(), 32'd0);
    step();
    rst_n = 1;
    ld_ack_i = 1;
    @(negedge clk);
    chk("stale_ack", {30'd0, lsu_stall_o, ld_timeout_o}, 32'd0);
    step();
    ld_ack_i = 0;
    @(negedge clk);
    chk("idle_after_rst", 32'(lsu_stall_o), 32'd0);
    step();

    // random stimulus against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < NSRC; j++)
        src_addr_i[j*REGW +: REGW] = REGW'($urandom_range(0, 3));
      for (int k = 0; k < NFWD; k++)
        prod_rd_i[k*REGW +: REGW] = REGW'($urandom_range(0, 3));
      src_use_i    = NSRC'($urandom);
      prod_wr_i    = NFWD'($urandom);
      prod_late_i  = NFWD'($urandom);
      ld_req_i     = ($urandom_range(0, 4) == 0);
      ld_ack_i     = ($urandom_range(0, 5) == 0);
      exe_pc_req_i = ($urandom_range(0, 2) == 0);
      csr_pc_req_i = ($urandom_range(0, 7) == 0);
      wfi_req_i    = ($urandom_range(0, 7) == 0);
      cnt_clr_i    = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      exp = model_eval();
      chk($sformatf("rand%0d", n), dut_vec(), exp);
      @(posedge clk);
      model_commit();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter NSRC, default 2, meaning source operands per EXE instruction (legal 2..3).
REQ-002 SHALL have parameter NFWD, default 2, meaning producer stages behind EXE (legal 1..4); index 0 is youngest (LSU), NFWD-1 is oldest.
REQ-003 SHALL have parameter REGW, default 5, meaning register address width.
REQ-004 SHALL have parameter LD_TO, default 0, meaning load-wait timeout in cycles; 0 disables the timeout.
REQ-005 SHALL have parameter CNTW, default 32, meaning width of each performance counter.
REQ-006 SHALL have ports in this order:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_addr_i  in  NSRC*REGW  EXE source addresses; operand j at [j*REGW +: REGW]
- src_use_i  in  NSRC  operand j is actually consumed
- prod_rd_i  in  NFWD*REGW  destination address per producer stage
- prod_wr_i  in  NFWD  producer stage writes rd
- prod_late_i  in  NFWD  result not yet available in that stage (load/CSR read)
- ld_req_i  in  1  LSU issues a data-bus load
- ld_ack_i  in  1  data-bus load response
- exe_pc_req_i, csr_pc_req_i, wfi_req_i  in  1 each  redirect requests
- cnt_clr_i  in  1  synchronous clear of both counters
- fwd_sel_o  out  NSRC*NFWD  one-hot forward select; operand j at [j*NFWD +: NFWD]
- front_stall_o  out  1  stall IF, IF/ID, ID/EXE
- lsu_stall_o  out  1  stall EXE/LSU
- front_flush_o  out  1  flush IF/ID and ID/EXE
- lsu_flush_o  out  1  flush EXE/LSU, inserting a bubble
- if_exe_pc_o, if_csr_pc_o, if_wfi_o  out  1 each  IF redirect controls
- ld_timeout_o  out  1  one-cycle timeout pulse
- stall_cnt_o, hazard_cnt_o  out  CNTW each  performance counters

Function
REQ-007 Match m[j][k] SHALL be src_addr[j]!=0 & src_addr[j]==prod_rd[k] & prod_wr[k].
REQ-008 For each operand, only the lowest matching k SHALL be selected; older matches SHALL be masked.
REQ-009 fwd_sel[j][k] SHALL be 1 only if k is selected and prod_late[k]=0; with no match, all bits for operand j SHALL be 0.
REQ-010 The use hazard, uh, SHALL be: OR over j of (selected k has prod_late[k]=1 & src_use[j]), masked by ld_stall.
REQ-011 The load FSM SHALL have states IDLE and WAIT:
- IDLE->WAIT on ld_req & ~ld_ack.
- WAIT->IDLE on ld_ack, or on timeout.
- ld_req & ld_ack in the same cycle SHALL stay in IDLE.
REQ-012 ld_stall SHALL be combinational: ~ld_ack & (ld_req | state==WAIT).
REQ-013 With LD_TO>0, a wait counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-014 When the wait counter reaches LD_TO-1 without an ack, the FSM SHALL return to IDLE and ld_timeout_o SHALL pulse for exactly 1 cycle; ld_stall SHALL still be 1 in that cycle.
REQ-015 An ack and the timeout in the same cycle SHALL be treated as an ack, with no pulse.
REQ-016 The effective EXE redirect SHALL be epc = exe_pc_req & ~(uh | ld_stall).
REQ-017 Control outputs SHALL be:
- front_stall_o = uh | ld_stall
- lsu_stall_o = ld_stall
- front_flush_o = epc | csr_pc_req | wfi_req
- lsu_flush_o = uh | csr_pc_req | wfi_req
- if_exe_pc_o = epc & ~csr_pc_req
- if_csr_pc_o = csr_pc_req
- if_wfi_o = wfi_req
REQ-018 A CSR redirect or WFI SHALL NOT abort a pending load; the FSM SHALL continue to wait for ack or timeout.
REQ-019 stall_cnt SHALL increment in every cycle where front_stall_o=1.
REQ-020 hazard_cnt SHALL increment in every cycle where uh=1.
REQ-021 Both counters SHALL saturate at all-ones; cnt_clr_i SHALL take priority over increment.

Reset
REQ-022 On rst_n=0, asynchronously: FSM=IDLE, wait counter=0, both counters=0, ld_timeout_o=0.
REQ-023 With all inputs 0 during reset, all outputs SHALL be 0.
REQ-024 Deasserting reset mid-load SHALL leave the FSM in IDLE; a stale ack after reset SHALL be ignored.

Verification
REQ-025 Defaults; src_addr={x3,x5}; prod_rd={x5,x5}, wr=11, late=00 -> fwd_sel operand1=01 (stage 0 only), operand0=00, no stall.
REQ-026 src0=x7, use=1; stage0 rd=x7, wr=1, late=1 -> front_stall=1, lsu_flush=1, hazard_cnt +1; same case with use=0 -> no stall.
REQ-027 ld_req 1 cycle, ld_ack 3 cycles later -> front_stall and lsu_stall high for exactly 4 cycles; exe_pc_req during the stall -> if_exe_pc_o=0.
REQ-028 LD_TO=4, ld_req, no ack -> ld_timeout_o pulses in the 4th WAIT cycle; FSM in IDLE the next cycle.
REQ-029 exe_pc_req & csr_pc_req together -> if_csr_pc_o=1, if_exe_pc_o=0, front_flush=1, lsu_flush=1.
REQ-030 CNTW=3; stall held 10 cycles -> stall_cnt=7; then cnt_clr_i with a stall present -> 0.
